uart_cmd_assembler: RTL and testbench
=====================================

// Module: uart_cmd_assembler
// PURPOSE
//  Sits between the UART transceiver and the command/config stage. Assembles three received
//  bytes (opcode, byte2, byte3; MSB first) into a 24-bit command, holds it with cmd_rdy until
//  the consumer clears it, and forwards the consumer's 1-byte responses to the UART transmitter
//  through a one-entry pending buffer.
// PARAMETERS
//  TIMEOUT_CYCLES  1_000_000  idle cycles allowed between bytes of a partial command (CMD_TIMEOUT_EN only)
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   reset, synchronous, active-low
//  rx_rdy       in   1   UART receiver holds a valid byte
//  rx_data      in   8   received byte
//  clr_rx_rdy   out  1   1-cycle pulse: byte consumed
//  cmd          out  24  assembled command {byte1,byte2,byte3}
//  cmd_rdy      out  1   cmd valid; held until clr_cmd_rdy
//  clr_cmd_rdy  in   1   consumer done with cmd
//  send_resp    in   1   1-cycle request to transmit resp_data
//  resp_data    in   8   response byte
//  tx_data      out  8   byte to UART transmitter
//  trmt         out  1   1-cycle pulse: start transmit
//  tx_done      in   1   1-cycle pulse: transmitter finished
//  resp_sent    out  1   1-cycle pulse, one cycle after tx_done
// BEHAVIOUR
//  - One clock (clk); reset synchronous active-low: all outputs 0, cmd=24'h0, FSM=BYTE1, buffers empty.
//  - Rx FSM: BYTE1 -> BYTE2 -> BYTE3 -> HOLD -> BYTE1.
//    BYTEn with rx_rdy=1 and clr_rx_rdy=0: capture rx_data into cmd slot n at the edge, clr_rx_rdy=1
//    next cycle; rx_rdy ignored in any cycle clr_rx_rdy is high (no double consume).
//  - Byte 3 capture edge also sets cmd_rdy and enters HOLD; cmd stable while cmd_rdy=1.
//  - HOLD: rx_rdy NOT consumed (byte left in receiver = backpressure). clr_cmd_rdy -> cmd_rdy=0
//    next edge, FSM=BYTE1. clr_cmd_rdy and rx_rdy same cycle: clear wins; byte consumed as byte1
//    starting the following cycle. clr_cmd_rdy outside HOLD: no effect.
//  - Tx path: idle + send_resp -> tx_data<=resp_data, trmt=1 next cycle, busy until tx_done.
//    Busy + send_resp with pending empty -> latch into pending; pending full -> request dropped.
//    tx_done with pending full -> pending issued (trmt) next cycle; resp_sent per completed byte.
//    tx_done and send_resp same cycle: new byte goes behind pending (order preserved).
//  - Rx and Tx paths independent; reset mid-command discards partial bytes and pending response.
// CONFIGURATION
//  CMD_TIMEOUT_EN defined: counter clears on every consumed byte, runs in BYTE2/BYTE3; on reaching
//    TIMEOUT_CYCLES the partial command is discarded, FSM=BYTE1, cmd unchanged, cmd_rdy stays 0.
//    Counter width $clog2(TIMEOUT_CYCLES+1); never runs in BYTE1/HOLD.
//  CMD_TIMEOUT_EN undefined: no counter; partial commands wait indefinitely; TIMEOUT_CYCLES unused.
// STRUCTURE
//  Package cmd_pkg: rx state enum (BYTE1,BYTE2,BYTE3,HOLD), CMD_BYTES=3, opcode localparams
//    (DUMP_CH..EEP_RD) shared with the command stage, positive-ack 8'hA5, error 8'hEE.
//  One sub-module: resp_tx_queue (idle/busy flag + 1-entry pending register, trmt/resp_sent gen).
// TESTING
//  1 bytes 8'h02,8'h05,8'h0C spaced 20 cycles -> cmd=24'h02050C, cmd_rdy=1, three clr_rx_rdy pulses.
//  2 4th byte 8'h07 during HOLD -> no clr_rx_rdy until clr_cmd_rdy; then consumed as byte1.
//  3 clr_cmd_rdy and rx_rdy same cycle -> cmd_rdy=0 next edge, byte consumed exactly once.
//  4 send_resp 8'hA5, then 8'hEE while busy, then 8'h11 while busy -> tx_data A5 then EE; 11 dropped;
//    two resp_sent pulses, each 1 cycle after tx_done.
//  5 CMD_TIMEOUT_EN, TIMEOUT_CYCLES=50: 8'h01 then silence 60 cycles, then 8'h06,8'h20,8'h00 ->
//    cmd=24'h062000 (stale byte discarded); without macro -> cmd=24'h010620.
//  6 rst_n low after 2 bytes and during busy tx -> all outputs 0, next 3 bytes form a fresh cmd.

Source files
------------

// File: rtl/cmd_pkg.sv
// Shared definitions for the UART command path: receive-state encoding, command geometry,
// opcodes understood by the command stage and the standard response bytes.
package cmd_pkg;

    typedef enum logic [1:0] {
        BYTE1 = 2'd0,
        BYTE2 = 2'd1,
        BYTE3 = 2'd2,
        HOLD  = 2'd3
    } rx_state_e;

    localparam int unsigned CMD_BYTES = 3;
    localparam int unsigned CMD_W     = 8 * CMD_BYTES;

    localparam logic [7:0] DUMP_CH  = 8'h01;
    localparam logic [7:0] CFG_GAIN = 8'h02;
    localparam logic [7:0] CFG_TRIG = 8'h03;
    localparam logic [7:0] CFG_OFFS = 8'h04;
    localparam logic [7:0] CFG_DEC  = 8'h05;
    localparam logic [7:0] EEP_WR   = 8'h08;
    localparam logic [7:0] EEP_RD   = 8'h09;

    localparam logic [7:0] POS_ACK  = 8'hA5;
    localparam logic [7:0] ERR_RESP = 8'hEE;

endpackage

// File: rtl/resp_tx_queue.sv
// Response path to the UART transmitter: one byte in flight plus a single pending slot.
// Requests arriving while both are occupied are dropped; order of accepted bytes is kept.
module resp_tx_queue (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_resp,
    input  logic [7:0] resp_data,
    input  logic       tx_done,
    output logic [7:0] tx_data,
    output logic       trmt,
    output logic       resp_sent
);

    logic       busy_r;
    logic       pend_vld_r;
    logic [7:0] pend_r;
    logic [7:0] tx_data_r;
    logic       trmt_r;
    logic       resp_sent_r;

    logic issue_new_s;
    logic issue_pend_s;
    logic latch_s;
    logic finish_s;

    assign tx_data   = tx_data_r;
    assign trmt      = trmt_r;
    assign resp_sent = resp_sent_r;

    // Decide what happens at the next edge: start a new byte, promote pending, or park a request.
    always_comb begin
        issue_new_s  = 1'b0;
        issue_pend_s = 1'b0;
        latch_s      = 1'b0;
        finish_s     = busy_r & tx_done;
        if (!busy_r) begin
            issue_new_s = send_resp;
        end else if (tx_done) begin
            if (pend_vld_r) begin
                issue_pend_s = 1'b1;
                latch_s      = send_resp;
            end else begin
                issue_new_s = send_resp;
            end
        end else begin
            latch_s = send_resp & ~pend_vld_r;
        end
    end

    // Transmit state, pending slot and registered strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r      <= 1'b0;
            pend_vld_r  <= 1'b0;
            pend_r      <= 8'h00;
            tx_data_r   <= 8'h00;
            trmt_r      <= 1'b0;
            resp_sent_r <= 1'b0;
        end else begin
            trmt_r      <= issue_new_s | issue_pend_s;
            resp_sent_r <= finish_s;
            if (issue_pend_s) begin
                tx_data_r <= pend_r;
            end else if (issue_new_s) begin
                tx_data_r <= resp_data;
            end
            if (issue_new_s || issue_pend_s) begin
                busy_r <= 1'b1;
            end else if (finish_s) begin
                busy_r <= 1'b0;
            end
            // A same-cycle latch refills the slot that is being promoted
            if (latch_s) begin
                pend_vld_r <= 1'b1;
                pend_r     <= resp_data;
            end else if (issue_pend_s) begin
                pend_vld_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_assembler.sv
// Assembles three UART bytes into a 24-bit command and forwards 1-byte responses to the transmitter.
// Optional macro CMD_TIMEOUT_EN discards a partial command after TIMEOUT_CYCLES idle cycles.
module uart_cmd_assembler
    import cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              clr_rx_rdy,
    output logic [CMD_W-1:0]  cmd,
    output logic              cmd_rdy,
    input  logic              clr_cmd_rdy,
    input  logic              send_resp,
    input  logic [7:0]        resp_data,
    output logic [7:0]        tx_data,
    output logic              trmt,
    input  logic              tx_done,
    output logic              resp_sent
);

    rx_state_e        state_r;
    rx_state_e        state_nxt_s;
    logic [CMD_W-1:0] cmd_r;
    logic             cmd_rdy_r;
    logic             clr_rx_rdy_r;

    logic take_s;
    logic timeout_s;
    logic cap1_s;
    logic cap2_s;
    logic cap3_s;
    logic release_s;

    assign cmd        = cmd_r;
    assign cmd_rdy    = cmd_rdy_r;
    assign clr_rx_rdy = clr_rx_rdy_r;

    // A byte is taken only while assembling and never during the consume pulse itself
    assign take_s = rx_rdy & ~clr_rx_rdy_r & (state_r != HOLD) & ~timeout_s;

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned     TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] idle_cnt_r;
    logic            partial_s;

    assign partial_s = (state_r == BYTE2) || (state_r == BYTE3);
    assign timeout_s = partial_s && (idle_cnt_r == TO_MAX);

    // Idle-cycle counter between bytes of a partial command.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt_r <= TO_W'(0);
        end else if (!partial_s || take_s || timeout_s) begin
            idle_cnt_r <= TO_W'(0);
        end else begin
            idle_cnt_r <= idle_cnt_r + TO_W'(1);
        end
    end
`else
    logic unused_timeout_cfg_s;

    assign timeout_s            = 1'b0;
    // TIMEOUT_CYCLES has no role when partial commands may wait forever
    assign unused_timeout_cfg_s = (TIMEOUT_CYCLES == 32'd0);
`endif

    // Receive FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= BYTE1;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Receive FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            BYTE1: begin
                if (take_s) state_nxt_s = BYTE2;
                else        state_nxt_s = BYTE1;
            end
            BYTE2: begin
                if (timeout_s)   state_nxt_s = BYTE1;
                else if (take_s) state_nxt_s = BYTE3;
                else             state_nxt_s = BYTE2;
            end
            BYTE3: begin
                if (timeout_s)   state_nxt_s = BYTE1;
                else if (take_s) state_nxt_s = HOLD;
                else             state_nxt_s = BYTE3;
            end
            HOLD: begin
                if (clr_cmd_rdy) state_nxt_s = BYTE1;
                else             state_nxt_s = HOLD;
            end
            default: state_nxt_s = BYTE1;
        endcase
    end

    // Receive FSM outputs: which command slot to load and when the held command is released.
    always_comb begin
        cap1_s    = 1'b0;
        cap2_s    = 1'b0;
        cap3_s    = 1'b0;
        release_s = 1'b0;
        case (state_r)
            BYTE1:   cap1_s    = take_s;
            BYTE2:   cap2_s    = take_s;
            BYTE3:   cap3_s    = take_s;
            HOLD:    release_s = clr_cmd_rdy;
            default: release_s = 1'b0;
        endcase
    end

    // Command register, ready flag and consume pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_r        <= 24'h000000;
            cmd_rdy_r    <= 1'b0;
            clr_rx_rdy_r <= 1'b0;
        end else begin
            clr_rx_rdy_r <= take_s;
            if (cap1_s) begin
                cmd_r[23:16] <= rx_data;
            end else if (cap2_s) begin
                cmd_r[15:8] <= rx_data;
            end else if (cap3_s) begin
                cmd_r[7:0] <= rx_data;
            end
            if (cap3_s) begin
                cmd_rdy_r <= 1'b1;
            end else if (release_s) begin
                cmd_rdy_r <= 1'b0;
            end
        end
    end

    resp_tx_queue u_resp_tx_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .send_resp (send_resp),
        .resp_data (resp_data),
        .tx_done   (tx_done),
        .tx_data   (tx_data),
        .trmt      (trmt),
        .resp_sent (resp_sent)
    );

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Self-checking bench for uart_cmd_assembler: a transaction-level model (byte count + response
// queue) is compared every cycle, and directed scenarios pin literal expected values.
module tb_uart_cmd_assembler;

    localparam int TOUT = 50;
`ifdef CMD_TIMEOUT_EN
    localparam bit TOUT_EN = 1'b1;
`else
    localparam bit TOUT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp_data;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done;
    logic        resp_sent;

    always #5 clk = ~clk;

    uart_cmd_assembler #(.TIMEOUT_CYCLES(TOUT)) dut (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .clr_rx_rdy(clr_rx_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .send_resp(send_resp), .resp_data(resp_data), .tx_data(tx_data), .trmt(trmt),
        .tx_done(tx_done), .resp_sent(resp_sent)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Behavioural model: number of bytes held so far, the command, and a 2-deep response queue
    bit         started = 1'b0;
    int         m_n = 0;
    int         m_idle = 0;
    logic [23:0] m_cmd = 24'h0;
    bit         m_rdy = 1'b0;
    bit         m_clr = 1'b0;
    logic [7:0] m_q[$];
    bit         m_trmt = 1'b0;
    bit         m_sent = 1'b0;
    logic [7:0] m_txd = 8'h00;
    bit         m_take, m_idle_b, m_popped;

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            started = 1'b1;
            m_n = 0; m_idle = 0; m_cmd = 24'h0; m_rdy = 1'b0; m_clr = 1'b0;
            m_q.delete(); m_trmt = 1'b0; m_sent = 1'b0; m_txd = 8'h00;
        end else begin
            m_take = 1'b0;
            if (m_n == 3) begin
                if (clr_cmd_rdy) begin m_n = 0; m_rdy = 1'b0; end
            end else if (TOUT_EN && m_n > 0 && m_idle == TOUT) begin
                m_n = 0; m_idle = 0;
            end else if (rx_rdy && !m_clr) begin
                m_cmd[8*(2-m_n) +: 8] = rx_data;
                m_n++; m_idle = 0; m_take = 1'b1;
                if (m_n == 3) m_rdy = 1'b1;
            end else if (m_n > 0) begin
                m_idle++;
            end
            m_clr = m_take;

            m_idle_b = (m_q.size() == 0);
            m_popped = 1'b0;
            m_sent   = tx_done && !m_idle_b;
            if (tx_done && !m_idle_b) begin void'(m_q.pop_front()); m_popped = 1'b1; end
            if (send_resp && m_q.size() < 2) m_q.push_back(resp_data);
            m_trmt = (m_q.size() > 0) && (m_idle_b || m_popped);
            if (m_trmt) m_txd = m_q[0];
        end
    end

    // Per-cycle compare against the model, plus pulse counters and a log of transmitted bytes
    int         clr_pulses = 0;
    int         sent_pulses = 0;
    logic [7:0] tx_log[$];

    initial forever begin
        @(negedge clk);
        if (started) begin
            check("clr_rx_rdy", {31'd0, clr_rx_rdy}, {31'd0, m_clr});
            check("cmd", {8'd0, cmd}, {8'd0, m_cmd});
            check("cmd_rdy", {31'd0, cmd_rdy}, {31'd0, m_rdy});
            check("trmt", {31'd0, trmt}, {31'd0, m_trmt});
            check("resp_sent", {31'd0, resp_sent}, {31'd0, m_sent});
            if (m_trmt) check("tx_data", {24'd0, tx_data}, {24'd0, m_txd});
            if (clr_rx_rdy) clr_pulses++;
            if (resp_sent) sent_pulses++;
            if (trmt) tx_log.push_back(tx_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_consume();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (clr_rx_rdy) got = 1'b1;
        end
        rx_rdy = 1'b0;
        check("rx_consume", {31'd0, got}, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_rdy  = 1'b1;
        rx_data = b;
        wait_consume();
    endtask

    task automatic clear_cmd();
        @(negedge clk); clr_cmd_rdy = 1'b1;
        @(negedge clk); clr_cmd_rdy = 1'b0;
    endtask

    task automatic pulse_resp(input logic [7:0] b);
        @(negedge clk); send_resp = 1'b1; resp_data = b;
        @(negedge clk); send_resp = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk); tx_done = 1'b1;
        @(negedge clk); tx_done = 1'b0;
        check("resp_sent_latency", {31'd0, resp_sent}, 32'd1);
    endtask

    int p0;
    int s0;

    initial begin
        rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; clr_cmd_rdy = 1'b0;
        send_resp = 1'b0; resp_data = 8'h00; tx_done = 1'b0;
        idle(3);
        check("rst_cmd", {8'd0, cmd}, 32'd0);
        check("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("rst_clr_rx_rdy", {31'd0, clr_rx_rdy}, 32'd0);
        check("rst_trmt", {31'd0, trmt}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // 1: three spaced bytes
        p0 = clr_pulses;
        send_byte(8'h02); idle(20);
        send_byte(8'h05); idle(20);
        send_byte(8'h0C); idle(3);
        check("t1_cmd", {8'd0, cmd}, 32'h0002050C);
        check("t1_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
        check("t1_pulses", clr_pulses - p0, 32'd3);

        // 2: fourth byte during HOLD is back-pressured
        p0 = clr_pulses;
        @(negedge clk); rx_rdy = 1'b1; rx_data = 8'h07;
        idle(10);
        check("t2_backpressure", clr_pulses - p0, 32'd0);
        check("t2_cmd_held", {8'd0, cmd}, 32'h0002050C);

        // 3: clear and pending byte in the same cycle
        clr_cmd_rdy = 1'b1;
        @(negedge clk); clr_cmd_rdy = 1'b0;
        check("t3_rdy_cleared", {31'd0, cmd_rdy}, 32'd0);
        check("t3_clear_wins", {31'd0, clr_rx_rdy}, 32'd0);
        wait_consume();
        idle(5);
        check("t3_single_consume", clr_pulses - p0, 32'd1);
        check("t3_cmd", {8'd0, cmd}, 32'h0007050C);
        send_byte(8'h08); send_byte(8'h09); idle(2);
        check("t3_cmd_full", {8'd0, cmd}, 32'h00070809);
        check("t3_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
        clear_cmd(); idle(2);

        // 5: stale partial command
        send_byte(8'h01); idle(60);
        check("t5_cmd_kept", {8'd0, cmd}, 32'h00010809);
        check("t5_not_rdy", {31'd0, cmd_rdy}, 32'd0);
        send_byte(8'h06); send_byte(8'h20);
`ifdef CMD_TIMEOUT_EN
        send_byte(8'h00); idle(2);
        check("t5_cmd_timeout", {8'd0, cmd}, 32'h00062000);
        check("t5_rdy", {31'd0, cmd_rdy}, 32'd1);
        clear_cmd(); idle(2);
`else
        idle(2);
        check("t5_cmd_no_timeout", {8'd0, cmd}, 32'h00010620);
        check("t5_rdy", {31'd0, cmd_rdy}, 32'd1);
        @(negedge clk); rx_rdy = 1'b1; rx_data = 8'h00; clr_cmd_rdy = 1'b1;
        @(negedge clk); clr_cmd_rdy = 1'b0;
        wait_consume();
        send_byte(8'h44); send_byte(8'h55); idle(2);
        check("t5_cmd_next", {8'd0, cmd}, 32'h00004455);
        clear_cmd(); idle(2);
`endif

        // 4: response queueing with one pending slot
        tx_log.delete(); s0 = sent_pulses;
        pulse_resp(8'hA5); idle(3);
        pulse_resp(8'hEE); idle(2);
        pulse_resp(8'h11); idle(5);
        pulse_done(); idle(5);
        pulse_done(); idle(5);
        check("t4_tx_count", tx_log.size(), 32'd2);
        if (tx_log.size() >= 2) begin
            check("t4_first", {24'd0, tx_log[0]}, 32'h000000A5);
            check("t4_second", {24'd0, tx_log[1]}, 32'h000000EE);
        end
        check("t4_sent", sent_pulses - s0, 32'd2);

        // 4b: tx_done and send_resp together with pending full
        tx_log.delete(); s0 = sent_pulses;
        pulse_resp(8'h21); idle(2);
        pulse_resp(8'h22); idle(2);
        @(negedge clk); tx_done = 1'b1; send_resp = 1'b1; resp_data = 8'h23;
        @(negedge clk); tx_done = 1'b0; send_resp = 1'b0;
        idle(3);
        pulse_done(); idle(3);
        pulse_done(); idle(3);
        check("t4b_tx_count", tx_log.size(), 32'd3);
        if (tx_log.size() >= 3) begin
            check("t4b_order0", {24'd0, tx_log[0]}, 32'h00000021);
            check("t4b_order1", {24'd0, tx_log[1]}, 32'h00000022);
            check("t4b_order2", {24'd0, tx_log[2]}, 32'h00000023);
        end
        check("t4b_sent", sent_pulses - s0, 32'd3);

        // 6: reset mid-command and mid-transmit
        send_byte(8'h31); send_byte(8'h32);
        pulse_resp(8'h5A); idle(2);
        pulse_resp(8'h5B); idle(2);
        @(negedge clk); rst_n = 1'b0;
        idle(2);
        check("t6_rst_cmd", {8'd0, cmd}, 32'd0);
        check("t6_rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("t6_rst_trmt", {31'd0, trmt}, 32'd0);
        check("t6_rst_resp_sent", {31'd0, resp_sent}, 32'd0);
        check("t6_rst_tx_data", {24'd0, tx_data}, 32'd0);
        rst_n = 1'b1;
        tx_log.delete();
        send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3); idle(2);
        check("t6_cmd", {8'd0, cmd}, 32'h00C1C2C3);
        check("t6_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
        pulse_resp(8'h77); idle(3);
        pulse_done(); idle(3);
        check("t6_tx_count", tx_log.size(), 32'd1);
        if (tx_log.size() >= 1) check("t6_tx_byte", {24'd0, tx_log[0]}, 32'h00000077);
        clear_cmd(); idle(3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
